// File: rtl/valid_shift_pipe_pkg.sv
// Shared constants and helpers for the data+valid shift pipeline.
package valid_shift_pipe_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 3;

   // Out-of-range tap requests select the last stage.
   function automatic int clamp_tap(input int sel, input int depth);
      return (sel >= depth) ? depth - 1 : sel;
   endfunction

endpackage

// File: rtl/valid_shift_pipe_edge_detect.sv
// Registered-history rise/fall detector for a single-bit strobe.
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic rise,
   output logic fall
);

   logic prev;

   // History is sampled every edge, independent of any pipeline enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev <= 1'b0;
      else     prev <= sig;
   end

   assign rise = sig & ~prev;
   assign fall = ~sig & prev;

endmodule

// File: rtl/valid_shift_pipe.sv
// Data+valid delay line with stall, flush, selectable output tap,
// edge detection on the tapped valid and a registered occupancy count.
module valid_shift_pipe
   import valid_shift_pipe_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int TAP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic [TAP_W-1:0] tap_sel,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_rise,
   output logic             out_fall,
   output logic [CNT_W-1:0] occupancy
);

   typedef struct packed {
      logic             v;
      logic [WIDTH-1:0] d;
   } stage_t;

   stage_t [DEPTH-1:0] stg;
   logic   [CNT_W-1:0] cnt;
   logic   [TAP_W-1:0] tap_idx;

   // Flush clears only the valid bits; payloads keep their last values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stg <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) stg[i].v <= 1'b0;
      end else if (en) begin
         stg[0].v <= in_valid;
         stg[0].d <= in_data;
         for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
      end
   end

   // Incremental count: what enters minus what falls off the end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        cnt <= '0;
      else if (flush) cnt <= '0;
      else if (en)    cnt <= cnt + CNT_W'(in_valid) - CNT_W'(stg[DEPTH-1].v);
   end

   assign tap_idx   = TAP_W'(clamp_tap(int'(tap_sel), DEPTH));
   assign out_valid = stg[tap_idx].v;
   assign out_data  = stg[tap_idx].d;
   assign occupancy = cnt;

   edge_detect u_edge (
      .clk  (clk),
      .rst  (rst),
      .sig  (out_valid),
      .rise (out_rise),
      .fall (out_fall)
   );

endmodule

// File: tb/tb_valid_shift_pipe.sv
// Scoreboard bench for valid_shift_pipe (WIDTH=8, DEPTH=3): directed stimulus,
// decoupled negedge monitor checking payload/latency and a valid-bit model.
module tb_valid_shift_pipe;

   localparam int WIDTH = 8;
   localparam int DEPTH = 3;
   localparam int TAP_W = 2;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic [TAP_W-1:0] tap_sel = 2'd2;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_rise;
   logic             out_fall;
   logic [CNT_W-1:0] occupancy;

   valid_shift_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .tap_sel   (tap_sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_rise  (out_rise),
      .out_fall  (out_fall),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] data;
      int               due;
   } exp_t;

   exp_t       sbq[$];
   int         n_pass = 0;
   int         n_total = 0;
   int         en_edges = 0;
   int         cyc = 0;
   logic       last_shift = 1'b0;
   logic [2:0] mv = '0;
   logic       mprev = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   function automatic int tapc();
      return (tap_sel >= 2'(DEPTH)) ? DEPTH - 1 : int'(tap_sel);
   endfunction

   // Reference valid-bit model and enabled-edge counter, updated from pre-edge inputs.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mv = '0;
         mprev = 1'b0;
         last_shift = 1'b0;
      end else begin
         cyc++;
         mprev = mv[tapc()];
         last_shift = en && !flush;
         if (flush)   mv = '0;
         else if (en) mv = {mv[1:0], in_valid};
         if (last_shift) en_edges++;
      end
   end

   // Monitor: model comparison every cycle, scoreboard pop on each newly shifted item.
   always @(negedge clk) begin
      logic ev;
      exp_t e;
      ev = mv[tapc()];
      check("mon_out_valid", 32'(out_valid), 32'(ev));
      check("mon_rise", 32'(out_rise), 32'(ev & ~mprev));
      check("mon_fall", 32'(out_fall), 32'(~ev & mprev));
      check("mon_occ_popcount", 32'(occupancy), 32'($countones(mv)));
      if (out_valid && last_shift) begin
         if (sbq.size() == 0) begin
            check("sb_unexpected_valid", 32'(out_valid), 32'd0);
         end else begin
            e = sbq.pop_front();
            check("sb_data", 32'(out_data), 32'(e.data));
            check("sb_latency", 32'(en_edges), 32'(e.due));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic e, input logic f);
      exp_t x;
      in_valid = v;
      in_data  = d;
      en       = e;
      flush    = f;
      if (f) begin
         for (int i = sbq.size() - 1; i >= 0; i--)
            if (sbq[i].due > en_edges) sbq.delete(i);
      end else if (v && e) begin
         x.data = d;
         x.due  = en_edges + tapc() + 1;
         sbq.push_back(x);
      end
   endtask

   task automatic pulse_latency(input logic [WIDTH-1:0] d, input string tag);
      drive(1'b1, d, 1'b1, 1'b0); tick();
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      check({tag, "_e1_valid"}, 32'(out_valid), 32'd0);
      tick();
      check({tag, "_e2_valid"}, 32'(out_valid), 32'd0);
      tick();
      check({tag, "_e3_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_e3_data"}, 32'(out_data), 32'(d));
      check({tag, "_e3_rise"}, 32'(out_rise), 32'd1);
      tick();
      check({tag, "_e4_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_e4_fall"}, 32'(out_fall), 32'd1);
      check({tag, "_e4_rise"}, 32'(out_rise), 32'd0);
      tick();
      check({tag, "_e5_fall"}, 32'(out_fall), 32'd0);
   endtask

   initial begin
      // Reset state
      tick(); tick();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_occ", 32'(occupancy), 32'd0);
      rst = 1'b0;
      tick();
      check("post_rst_valid", 32'(out_valid), 32'd0);
      check("post_rst_rise", 32'(out_rise), 32'd0);
      check("post_rst_occ", 32'(occupancy), 32'd0);

      // Latency and pulse width at tap 2
      pulse_latency(8'hA5, "lat");

      // Stall: two dead cycles after capture
      drive(1'b1, 8'h3C, 1'b1, 1'b0); tick();
      check("stall_occ_e1", 32'(occupancy), 32'd1);
      drive(1'b0, 8'hFF, 1'b0, 1'b0); tick();
      check("stall_occ_e2", 32'(occupancy), 32'd1);
      drive(1'b1, 8'hEE, 1'b0, 1'b0); tick();
      check("stall_occ_e3", 32'(occupancy), 32'd1);
      check("stall_e3_valid", 32'(out_valid), 32'd0);
      drive(1'b0, 8'h00, 1'b1, 1'b0); tick();
      check("stall_occ_e4", 32'(occupancy), 32'd1);
      check("stall_e4_valid", 32'(out_valid), 32'd0);
      tick();
      check("stall_e5_valid", 32'(out_valid), 32'd1);
      check("stall_e5_data", 32'(out_data), 32'h3C);
      check("stall_occ_e5", 32'(occupancy), 32'd1);
      tick();
      check("stall_occ_e6", 32'(occupancy), 32'd0);
      tick();

      // Flush with a valid input in the same cycle
      drive(1'b1, 8'h11, 1'b1, 1'b0); tick();
      drive(1'b1, 8'h22, 1'b1, 1'b0); tick();
      drive(1'b1, 8'h33, 1'b1, 1'b0); tick();
      check("flush_pre_occ", 32'(occupancy), 32'd3);
      check("flush_pre_data", 32'(out_data), 32'h11);
      drive(1'b1, 8'h44, 1'b1, 1'b1); tick();
      check("flush_occ", 32'(occupancy), 32'd0);
      check("flush_valid", 32'(out_valid), 32'd0);
      check("flush_fall", 32'(out_fall), 32'd1);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      tap_sel = 2'd0;
      #1;
      check("flush_stage0_valid", 32'(out_valid), 32'd0);
      check("flush_stage0_data_held", 32'(out_data), 32'h33);
      tick();
      check("flush_fall_once", 32'(out_fall), 32'd0);
      tap_sel = 2'd2;
      tick(); tick();

      // Out-of-range tap behaves as the last stage
      tap_sel = 2'd3;
      pulse_latency(8'h5A, "clamp");
      tap_sel = 2'd2;

      // Continuous stream: ramp, hold, drain
      for (int k = 1; k <= 10; k++) begin
         drive(1'b1, 8'(8'h10 + k), 1'b1, 1'b0); tick();
         check("stream_occ", 32'(occupancy), 32'((k < 3) ? k : 3));
      end
      for (int k = 2; k >= 0; k--) begin
         drive(1'b0, 8'h00, 1'b1, 1'b0); tick();
         check("drain_occ", 32'(occupancy), 32'(k));
      end
      tick();

      // Asynchronous reset with three valids in flight
      drive(1'b1, 8'h71, 1'b1, 1'b0); tick();
      drive(1'b1, 8'h72, 1'b1, 1'b0); tick();
      drive(1'b1, 8'h73, 1'b1, 1'b0); tick();
      check("midrst_pre_occ", 32'(occupancy), 32'd3);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      rst = 1'b1;
      sbq.delete();
      #1;
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_occ", 32'(occupancy), 32'd0);
      check("midrst_fall", 32'(out_fall), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      check("postrst_fall", 32'(out_fall), 32'd0);
      check("postrst_valid", 32'(out_valid), 32'd0);
      tick(); tick();

      check("sb_drained", 32'(sbq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
